trb_mem_arbiter: RTL

TRB_MEM_ARBITER -- requirements
Module: trb_mem_arbiter

---
 rtl/dtb_pkg.sv | 7 +
 rtl/trb_mem_arbiter.sv | 64 ++++++
 2 files changed

// File: rtl/dtb_pkg.sv
// dtb_pkg: shared trace-buffer widths and arbiter slot encoding.
package dtb_pkg;
  localparam int TRB_WIDTH = 8;
  localparam int TRB_ADDR_WIDTH = 3;
  localparam int TRB_DEPTH = 2 ** TRB_ADDR_WIDTH;
  typedef enum logic [1:0] {W, R, H} slot_t;
endpackage

// File: rtl/trb_mem_arbiter.sv
// trb_mem_arbiter: time-slots one BRAM port between logger writes, logger reads and host peeks.
module trb_mem_arbiter
  import dtb_pkg::*;
(
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic                      FLUSH_I,
  input  logic                      LOG_WRITE_I,
  input  logic [TRB_ADDR_WIDTH-1:0] LOG_WPTR_I,
  input  logic [TRB_WIDTH-1:0]      LOG_WDATA_I,
  input  logic                      LOG_READ_I,
  input  logic [TRB_ADDR_WIDTH-1:0] LOG_RPTR_I,
  output logic [TRB_WIDTH-1:0]      LOG_RDATA_O,
  output logic                      RW_TURN_O,
  output logic                      WRITE_ALLOW_O,
  output logic                      READ_ALLOW_O,
  input  logic                      HOST_REQ_I,
  input  logic [TRB_ADDR_WIDTH-1:0] HOST_ADDR_I,
  output logic                      HOST_GNT_O,
  output logic                      HOST_VALID_O,
  output logic [TRB_WIDTH-1:0]      HOST_RDATA_O,
  output logic [TRB_ADDR_WIDTH-1:0] MEM_ADDR_O,
  output logic                      MEM_WE_O,
  output logic [TRB_WIDTH-1:0]      MEM_WDATA_O,
  input  logic [TRB_WIDTH-1:0]      MEM_RDATA_I
);
  localparam logic [TRB_ADDR_WIDTH:0] CNT_FULL = TRB_DEPTH[TRB_ADDR_WIDTH:0];
  localparam logic [TRB_ADDR_WIDTH:0] CNT_ONE = 1;
  slot_t state, state_nxt;
  logic [TRB_ADDR_WIDTH:0] cnt;
  logic was_r, was_h, wr_commit, rd_commit;
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) state <= W;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == W ? R : (state == R && HOST_REQ_I) ? H : W;
    RW_TURN_O = state == W;
    HOST_GNT_O = state == H;
    MEM_ADDR_O = state == W ? LOG_WPTR_I : state == R ? LOG_RPTR_I : HOST_ADDR_I;
    wr_commit = (state == W) & LOG_WRITE_I & WRITE_ALLOW_O;
    rd_commit = (state == R) & LOG_READ_I & READ_ALLOW_O;
    MEM_WE_O = wr_commit;
  end
  assign WRITE_ALLOW_O = cnt != CNT_FULL;
  assign READ_ALLOW_O = cnt != '0;
  assign MEM_WDATA_O = LOG_WDATA_I;
  // BRAM data lands one cycle after the slot, so capture is keyed off the previous slot
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      cnt <= '0;
      was_r <= 1'b0;
      was_h <= 1'b0;
      LOG_RDATA_O <= '0;
      HOST_RDATA_O <= '0;
      HOST_VALID_O <= 1'b0;
    end else begin
      cnt <= FLUSH_I ? '0 : wr_commit ? cnt + CNT_ONE : rd_commit ? cnt - CNT_ONE : cnt;
      was_r <= state == R;
      was_h <= state == H;
      HOST_VALID_O <= was_h;
      if (was_r) LOG_RDATA_O <= MEM_RDATA_I;
      if (was_h) HOST_RDATA_O <= MEM_RDATA_I;
    end
endmodule
